alu_uart_ctrl: RTL and testbench

Sequencer between the UART receiver/transmitter pair and the combinational `alu` in the TP2 datapath. It collects three serial bytes in order: operand A, operand B, opcode. It then drives them onto the ALU and captures the result and flags. It returns two bytes over the UART transmitter: result, then a flags byte. An inter-byte timeout discards stalled frames so a lost byte cannot desynchronise the host.

---
 rtl/alu_uart_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alu_uart_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl.sv
// UART-to-ALU sequencer: collects A, B, opcode bytes,
// runs the ALU and returns result and flags bytes.
module alu_uart_ctrl #(
  parameter int N       = 8,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] rx_data,
  input  logic         rx_done,
  input  logic         tx_done,
  output logic         tx_start,
  output logic [N-1:0] tx_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_carry,
  output logic         busy,
  output logic         timeout
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND_RES,
    WAIT_RES,
    SEND_FLG,
    WAIT_FLG
  } state_t;

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          expire;
  logic          op_err;
  logic [N-1:0]  res_q;
  logic [N-1:0]  flg_q;
  logic [N-1:0]  res_n;
  logic [N-1:0]  flg_n;

  function automatic logic op_valid(
    input logic [N-1:0] b
  );
    logic ok;
    case (b[5:0])
      6'b100000,
      6'b100010,
      6'b100100,
      6'b100101,
      6'b100110,
      6'b100111,
      6'b000010,
      6'b000011: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok && (b[7:6] == 2'b00);
  endfunction

  assign expire = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign busy   = (state != WAIT_A);

  assign res_n = op_err ? '0 : alu_result;
  assign flg_n = op_err ?
    {1'b1, {(N-1){1'b0}}} :
    {{(N-2){1'b0}}, alu_carry, alu_zero};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_A;
    else       state <= state_n;
  end

  // Next-state, tx_start and timeout pulse decode
  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      WAIT_A:
        if (rx_done) state_n = WAIT_B;
      WAIT_B:
        if (rx_done) begin
          state_n = WAIT_OP;
        end else if (expire) begin
          timeout = 1'b1;
          state_n = WAIT_A;
        end
      WAIT_OP:
        if (rx_done) begin
          state_n = EXEC;
        end else if (expire) begin
          timeout = 1'b1;
          state_n = WAIT_A;
        end
      EXEC:
        state_n = SEND_RES;
      SEND_RES: begin
        tx_start = 1'b1;
        state_n  = WAIT_RES;
      end
      WAIT_RES:
        if (tx_done) state_n = SEND_FLG;
      SEND_FLG: begin
        tx_start = 1'b1;
        state_n  = WAIT_FLG;
      end
      WAIT_FLG:
        if (tx_done) state_n = WAIT_A;
      default:
        state_n = WAIT_A;
    endcase
  end

  // Inter-byte counter; runs only mid-frame
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == WAIT_B ||
                  state == WAIT_OP) && !rx_done) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Operand, opcode and result/flags capture
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      op_err  <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      tx_data <= '0;
    end else begin
      if (state == WAIT_A && rx_done)
        alu_a <= rx_data;
      if (state == WAIT_B && rx_done)
        alu_b <= rx_data;
      if (state == WAIT_OP && rx_done) begin
        alu_op <= rx_data[5:0];
        op_err <= !op_valid(rx_data);
      end
      if (state == EXEC) begin
        res_q   <= res_n;
        flg_q   <= flg_n;
        tx_data <= res_n;
      end
      if (state == WAIT_RES && tx_done)
        tx_data <= flg_q;
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a
// behavioural ALU model on the datapath side.
module tb_alu_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  logic       busy;
  logic       timeout;

  int passed = 0;
  int total  = 0;

  alu_uart_ctrl #(.N(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  logic [8:0] wide;
  always_comb begin
    wide = 9'd0;
    case (alu_op)
      6'h20: wide = {1'b0, alu_a} + {1'b0, alu_b};
      6'h22: wide = {1'b0, alu_a} - {1'b0, alu_b};
      6'h24: wide = {1'b0, alu_a & alu_b};
      6'h25: wide = {1'b0, alu_a | alu_b};
      6'h26: wide = {1'b0, alu_a ^ alu_b};
      6'h27: wide = {1'b0, ~(alu_a | alu_b)};
      6'h02: wide = {1'b0, alu_a >> alu_b};
      6'h03: wide = {1'b0,
               8'($signed(alu_a) >>> alu_b)};
      default: wide = 9'd0;
    endcase
  end
  assign alu_result = wide[7:0];
  assign alu_carry  = wide[8];
  assign alu_zero   = (wide[7:0] == 8'h00);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    total++;
    if ({busy, tx_start, timeout} !== 3'b000)
      $display("FAIL reset_ctl got=%b want=000",
               {busy, tx_start, timeout});
    else passed++;
    total++;
    if ({alu_a, alu_b, alu_op, tx_data} !== 30'd0)
      $display("FAIL reset_regs got=%h want=0",
               {alu_a, alu_b, alu_op, tx_data});
    else passed++;
  endtask

  task automatic run_frame(
    input string      name,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] op,
    input logic [7:0] res,
    input logic [7:0] flg,
    input bit         drop
  );
    send_byte(a);
    total++;
    if (busy !== 1'b1)
      $display("FAIL %s busy_after_a got=%b want=1",
               name, busy);
    else passed++;
    send_byte(b);
    send_byte(op);
    total++;
    if ({tx_start, alu_a, alu_b, alu_op} !==
        {1'b0, a, b, op[5:0]})
      $display("FAIL %s exec got=%h want=%h", name,
               {tx_start, alu_a, alu_b, alu_op},
               {1'b0, a, b, op[5:0]});
    else passed++;
    step();
    total++;
    if ({tx_start, tx_data} !== {1'b1, res})
      $display("FAIL %s res_send got=%h want=%h",
               name, {tx_start, tx_data}, {1'b1, res});
    else passed++;
    step();
    if (drop) begin
      rx_data = 8'h77;
      rx_done = 1'b1;
    end
    step();
    rx_done = 1'b0;
    step();
    total++;
    if ({tx_start, tx_data} !== {1'b0, res})
      $display("FAIL %s res_hold got=%h want=%h",
               name, {tx_start, tx_data}, {1'b0, res});
    else passed++;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if ({tx_start, tx_data} !== {1'b1, flg})
      $display("FAIL %s flg_send got=%h want=%h",
               name, {tx_start, tx_data}, {1'b1, flg});
    else passed++;
    step();
    total++;
    if ({tx_start, busy} !== 2'b01)
      $display("FAIL %s flg_wait got=%b want=01",
               name, {tx_start, busy});
    else passed++;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if ({busy, tx_data} !== {1'b0, flg})
      $display("FAIL %s done got=%h want=%h",
               name, {busy, tx_data}, {1'b0, flg});
    else passed++;
    if (drop) begin
      total++;
      if (alu_a !== a)
        $display("FAIL %s drop got=%h want=%h",
                 name, alu_a, a);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int at;
    pulses = 0;
    at     = -1;
    send_byte(8'hAA);
    for (int i = 0; i < 20; i++) begin
      if (timeout === 1'b1) begin
        pulses++;
        at = i;
      end
      step();
    end
    total++;
    if (pulses !== 1 || at !== 15)
      $display("FAIL to_pulse got=%0d@%0d want=1@15",
               pulses, at);
    else passed++;
    total++;
    if ({busy, alu_a} !== {1'b0, 8'hAA})
      $display("FAIL to_idle got=%h want=0aa",
               {busy, alu_a});
    else passed++;
    run_frame("to_resync", 8'h01, 8'h02, 8'h20,
              8'h03, 8'h00, 1'b0);
  endtask

  task automatic test_expiry_race();
    send_byte(8'h09);
    for (int i = 0; i < 15; i++) step();
    rx_data = 8'h04;
    rx_done = 1'b1;
    #1;
    total++;
    if (timeout !== 1'b0)
      $display("FAIL race_to got=%b want=0", timeout);
    else passed++;
    step();
    rx_done = 1'b0;
    send_byte(8'h22);
    total++;
    if ({alu_a, alu_b} !== 16'h0904)
      $display("FAIL race_ops got=%h want=0904",
               {alu_a, alu_b});
    else passed++;
    step();
    total++;
    if ({tx_start, tx_data} !== {1'b1, 8'h05})
      $display("FAIL race_res got=%h want=105",
               {tx_start, tx_data});
    else passed++;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int starts;
    starts = 0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h20);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({busy, tx_start, alu_a} !== 10'd0)
      $display("FAIL rst_mid got=%h want=0",
               {busy, tx_start, alu_a});
    else passed++;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tx_start === 1'b1) starts++;
      step();
    end
    total++;
    if (starts !== 0 || busy !== 1'b0)
      $display("FAIL rst_quiet got=%0d/%b want=0/0",
               starts, busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    run_frame("add", 8'h0F, 8'h01, 8'h20,
              8'h10, 8'h00, 1'b0);
    run_frame("add_ovf", 8'hFF, 8'h01, 8'h20,
              8'h00, 8'h03, 1'b0);
    run_frame("sub_brw", 8'h05, 8'h07, 8'h22,
              8'hFE, 8'h02, 1'b1);
    run_frame("sra", 8'h80, 8'h01, 8'h03,
              8'h80 >> 1 | 8'h80, 8'h00, 1'b0);
    run_frame("and_zero", 8'hF0, 8'h0F, 8'h24,
              8'h00, 8'h01, 1'b0);
    run_frame("bad_op", 8'h12, 8'h34, 8'h3F,
              8'h00, 8'h80, 1'b0);
    run_frame("bad_hi", 8'h12, 8'h34, 8'hE0,
              8'h00, 8'h80, 1'b0);
    test_timeout();
    test_expiry_race();
    test_reset_mid();
    run_frame("post_rst", 8'h0C, 8'h0A, 8'h26,
              8'h06, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
